// File: rtl/mem_port_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-outstanding memory port.
// Optional macro ARB_ALT_PRIORITY_EN: alternate grants on ties instead of data-first.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_resp,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W/8-1:0] data_mbe,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_resp,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_mbe,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_t;

    state_t r_state;
    logic   w_pend_data;
    logic   w_grant_data;

    assign w_pend_data = data_read | data_write;

`ifdef ARB_ALT_PRIORITY_EN
    // 1 = data port won the most recent grant; resets to "instruction".
    logic r_last_data;

    assign w_grant_data = w_pend_data & (~inst_read | ~r_last_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_data <= 1'b0;
        else if (r_state == IDLE && (w_pend_data || inst_read))
            r_last_data <= w_grant_data;
    end
`else
    assign w_grant_data = w_pend_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_mbe    <= '0;
            mem_wdata  <= '0;
            inst_resp  <= 1'b0;
            data_resp  <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_resp <= 1'b0;
            data_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Everything the memory sees is latched here, so the
                    // requester may change its inputs while in flight.
                    if (w_grant_data) begin
                        r_state   <= DATA;
                        mem_addr  <= data_addr;
                        mem_mbe   <= data_mbe;
                        mem_wdata <= data_wdata;
                        mem_write <= data_write;
                        mem_read  <= ~data_write;
                    end else if (inst_read) begin
                        r_state   <= INST;
                        mem_addr  <= inst_addr;
                        mem_mbe   <= '1;
                        mem_wdata <= '0;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                INST, DATA: begin
                    if (mem_resp) begin
                        r_state   <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (r_state == INST) begin
                            inst_rdata <= mem_rdata;
                            inst_resp  <= 1'b1;
                        end else begin
                            data_rdata <= mem_rdata;
                            data_resp  <= 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
